// File: rtl/pipe_hazard_unit_if.sv
// ID-stage hazard/forwarding bundle: the pipeline (master) drives the instruction and operand
// fields, and the hazard unit (slave) returns the stall, the forwarded operands and the counters.
interface pipe_hazard_unit_if #(
    parameter int STAGES = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int SEL_W  = 2
);
    logic                     adv_en;
    logic                     flush;
    logic                     id_valid;
    logic [ADDR_W-1:0]        id_rs_addr;
    logic [ADDR_W-1:0]        id_rt_addr;
    logic                     id_rs_used;
    logic                     id_rt_used;
    logic                     id_wen;
    logic [ADDR_W-1:0]        id_wd_addr;
    logic                     id_is_load;
    logic [DATA_W-1:0]        rf_rs_data;
    logic [DATA_W-1:0]        rf_rt_data;
    logic [STAGES*DATA_W-1:0] stage_result;
    logic                     stall_id;
    logic [DATA_W-1:0]        fwd_rs_data;
    logic [DATA_W-1:0]        fwd_rt_data;
    logic [SEL_W-1:0]         fwd_rs_sel;
    logic [SEL_W-1:0]         fwd_rt_sel;
    logic [31:0]              stall_cnt;
    logic [31:0]              fwd_cnt;

    // Valid/ready note: there is no handshake; every field is sampled each cycle, and
    // the pipeline advances only when adv_en=1.
    modport master (
        output adv_en, flush, id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               id_wen, id_wd_addr, id_is_load, rf_rs_data, rf_rt_data, stage_result,
        input  stall_id, fwd_rs_data, fwd_rt_data, fwd_rs_sel, fwd_rt_sel, stall_cnt, fwd_cnt
    );
    modport slave (
        input  adv_en, flush, id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               id_wen, id_wd_addr, id_is_load, rf_rs_data, rf_rt_data, stage_result,
        output stall_id, fwd_rs_data, fwd_rt_data, fwd_rs_sel, fwd_rt_sel, stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard tracking and operand forwarding for the ID stage over STAGES post-ID stages.
// Optional perf counters are enabled by defining HAZARD_PERF_EN.
module pipe_hazard_unit #(
    parameter int STAGES     = 3,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int ALU_STAGE  = 0,
    parameter int LOAD_STAGE = 1,
    parameter int SEL_W      = 2
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_unit_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic              wen;
        logic [ADDR_W-1:0] waddr;
        logic              load;
    } rec_t;

    rec_t                rec [STAGES];
    logic [STAGES-1:0]   stage_rdy;
    logic [ADDR_W-1:0]   op_addr [2];
    logic [DATA_W-1:0]   rf_data [2];
    logic                op_hit  [2];
    logic                op_rdy  [2];
    logic [SEL_W-1:0]    op_sel  [2];
    logic [DATA_W-1:0]   op_data [2];
    logic                stall;

    assign op_addr[0] = bus.id_rs_addr;
    assign op_addr[1] = bus.id_rt_addr;
    assign rf_data[0] = bus.rf_rs_data;
    assign rf_data[1] = bus.rf_rt_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) rec[k] <= '0;
        end else if (bus.adv_en) begin
            if (stall || bus.flush) rec[0] <= '0;
            else rec[0] <= '{valid: bus.id_valid, wen: bus.id_wen,
                             waddr: bus.id_wd_addr, load: bus.id_is_load};
            for (int k = 1; k < STAGES; k++) rec[k] <= rec[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++)
            stage_rdy[k] = (k >= (rec[k].load ? LOAD_STAGE : ALU_STAGE));
    end

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        for (int o = 0; o < 2; o++) begin
            op_hit[o]  = 1'b0;
            op_rdy[o]  = 1'b0;
            op_sel[o]  = '0;
            op_data[o] = rf_data[o];
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (rec[k].valid && rec[k].wen && rec[k].waddr == op_addr[o] &&
                    rec[k].waddr != '0) begin
                    op_hit[o]  = 1'b1;
                    op_rdy[o]  = stage_rdy[k];
                    op_sel[o]  = SEL_W'(k + 1);
                    op_data[o] = bus.stage_result[k*DATA_W +: DATA_W];
                end
            end
            // A not-yet-ready producer falls back to the regfile value while ID stalls.
            if (op_hit[o] && !op_rdy[o]) begin
                op_sel[o]  = '0;
                op_data[o] = rf_data[o];
            end
        end
    end

    assign stall = bus.id_valid && !bus.flush &&
                   ((bus.id_rs_used && op_hit[0] && !op_rdy[0]) ||
                    (bus.id_rt_used && op_hit[1] && !op_rdy[1]));

    assign bus.stall_id    = stall;
    assign bus.fwd_rs_data = op_data[0];
    assign bus.fwd_rt_data = op_data[1];
    assign bus.fwd_rs_sel  = op_sel[0];
    assign bus.fwd_rt_sel  = op_sel[1];

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;
    logic        fwd_evt;

    assign fwd_evt = bus.adv_en && bus.id_valid && !stall && !bus.flush &&
                     ((bus.id_rs_used && op_sel[0] != '0) ||
                      (bus.id_rt_used && op_sel[1] != '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (bus.adv_en && stall && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (fwd_evt && fwd_cnt_q != 32'hFFFF_FFFF)
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;
`else
    assign bus.stall_cnt = '0;
    assign bus.fwd_cnt   = '0;
`endif
endmodule
